// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ_REQ,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_EVEN = 2'd1,
        PARITY_ODD  = 2'd2
    } parity_t;

    function automatic int unsigned clocks_per_bit(input int unsigned freq, input int unsigned baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: tick is high on the last clock of each bit period, clr restarts the period.
// Single-cycle tick, no backpressure; clr has priority over wrap.
module uart_baud_tick #(
    parameter int unsigned CLOCKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (CLOCKS_PER_BIT > 2) ? $clog2(CLOCKS_PER_BIT) : 1;

    logic [CW-1:0] count;

    assign tick = (count == CW'(CLOCKS_PER_BIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr || tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_framer.sv
// Parametrised UART transmitter: pops one word per frame from a FIFO, sends start/data/parity/stop, dout registered.
// Start edge 3 clocks after FIFO goes non-empty; waits in IDLE while empty (or while CTS is held off with UART_TX_CTS_EN).
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter logic [31:0]  CLOCK_FREQUENCY = 32'd100_000_000,
    parameter logic [31:0]  BAUD_RATE       = 32'd115200,
    parameter int unsigned  WORD_WIDTH      = 32'd8,
    parameter logic [1:0]   PARITY_MODE     = 2'd0,
    parameter int unsigned  STOP_BITS       = 32'd1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] din,
    input  logic                  empty,
`ifdef UART_TX_CTS_EN
    input  logic                  cts_n,
`endif
    output logic                  re,
    output logic                  dout,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int unsigned CPB = clocks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int unsigned BCW = $clog2(WORD_WIDTH + 1);

    if (CPB < 2) begin : g_bad_cpb
        $error("uart_tx_framer: CLOCK_FREQUENCY / BAUD_RATE must be at least 2");
    end
    if (WORD_WIDTH < 5 || WORD_WIDTH > 9) begin : g_bad_width
        $error("uart_tx_framer: WORD_WIDTH must be 5..9");
    end
    if (PARITY_MODE == 2'd3) begin : g_bad_parity
        $error("uart_tx_framer: PARITY_MODE 3 is illegal");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_framer: STOP_BITS must be 1 or 2");
    end

    state_t                state, state_nx;
    logic [WORD_WIDTH-1:0] shreg, shreg_nx;
    logic                  parity_bit, parity_nx;
    logic [BCW-1:0]        bit_cnt, bit_cnt_nx;
    logic                  dout_nx;
    logic                  tick;
    logic                  clr;
    logic                  cts_ok;

`ifdef UART_TX_CTS_EN
    logic [1:0] cts_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cts_sync <= 2'b11;
        end else begin
            cts_sync <= {cts_sync[0], cts_n};
        end
    end

    assign cts_ok = ~cts_sync[1];
`else
    assign cts_ok = 1'b1;
`endif

    // The period counter restarts on every state change and idles outside the bit-timed states.
    assign clr = (state_nx != state) || (state == IDLE) || (state == READ_REQ) || (state == LOAD);

    uart_baud_tick #(
        .CLOCKS_PER_BIT (CPB)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

    always_comb begin
        state_nx   = state;
        shreg_nx   = shreg;
        parity_nx  = parity_bit;
        bit_cnt_nx = bit_cnt;
        tx_done    = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && cts_ok) begin
                    state_nx = READ_REQ;
                end
            end
            READ_REQ: state_nx = LOAD;
            LOAD: begin
                shreg_nx  = din;
                parity_nx = (^din) ^ (PARITY_MODE == PARITY_ODD);
                state_nx  = START;
            end
            START: begin
                if (tick) begin
                    state_nx = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_nx = shreg >> 1;
                    if (bit_cnt == BCW'(WORD_WIDTH - 1)) begin
                        bit_cnt_nx = '0;
                        state_nx   = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
                    end else begin
                        bit_cnt_nx = bit_cnt + BCW'(1);
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_nx = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    if (bit_cnt == BCW'(STOP_BITS - 1)) begin
                        tx_done    = 1'b1;
                        bit_cnt_nx = '0;
                        state_nx   = IDLE;
                    end else begin
                        bit_cnt_nx = bit_cnt + BCW'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        // Line level is decoded from next-cycle state so the registered pin lines up with the state.
        case (state_nx)
            START:   dout_nx = 1'b0;
            DATA:    dout_nx = shreg_nx[0];
            PARITY:  dout_nx = parity_nx;
            default: dout_nx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            parity_bit <= 1'b0;
            bit_cnt    <= '0;
            dout       <= 1'b1;
        end else begin
            state      <= state_nx;
            shreg      <= shreg_nx;
            parity_bit <= parity_nx;
            bit_cnt    <= bit_cnt_nx;
            dout       <= dout_nx;
        end
    end

    assign re   = (state == READ_REQ);
    assign busy = (state != IDLE);

endmodule
